reg_op_sequencer: RTL and testbench

Command-driven sequencer that owns the port side of the 16 × 32-bit register bank (two combinational read ports, one clocked write port). It accepts one three-address command at a time over a valid/ready handshake, reads the source registers, computes the result, and writes it back through the bank's write port. It is the register bank's only client, sitting between the instruction source and the bank.

---
 rtl/reg_seq_pkg.sv | 26 ++
 rtl/reg_seq_alu.sv | 48 ++++
 rtl/reg_op_sequencer.sv | 123 ++++++++++++
 tb/tb_reg_op_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/reg_seq_pkg.sv
// Shared types and defaults for the register-bank command sequencer.
package reg_seq_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 4;
    localparam int IW_DEF = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MOV  = 3'd5,
        OP_LDI  = 3'd6,
        OP_ADDI = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/reg_seq_alu.sv
// Combinational ALU: result, carry/borrow and zero flag for one command.
module reg_seq_alu
    import reg_seq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  op_e           op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] imm_i,
    output logic [DW-1:0] y_o,
    output logic          c_o,
    output logic          z_o
);

    logic [DW:0] sum;

    always_comb begin
        sum = '0;
        y_o = '0;
        c_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                sum = {1'b0, a_i} + {1'b0, b_i};
                y_o = sum[DW-1:0];
                c_o = sum[DW];
            end
            OP_SUB: begin
                y_o = a_i - b_i;
                c_o = (a_i < b_i);
            end
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_MOV:  y_o = a_i;
            OP_LDI:  y_o = imm_i;
            OP_ADDI: begin
                sum = {1'b0, a_i} + {1'b0, imm_i};
                y_o = sum[DW-1:0];
                c_o = sum[DW];
            end
            default: y_o = '0;
        endcase
    end

    assign z_o = (y_o == '0);

endmodule

// File: rtl/reg_op_sequencer.sv
// Four-cycle read/exec/write sequencer driving the register bank ports.
module reg_op_sequencer
    import reg_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [IW-1:0] cmd_imm,
    output logic [AW-1:0] ra1,
    input  logic [DW-1:0] rd1,
    output logic [AW-1:0] ra2,
    input  logic [DW-1:0] rd2,
    output logic          w_en,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          flag_z,
    output logic          flag_c
);

    state_e        state_q, state_d;
    op_e           op_q;
    logic [AW-1:0] rd_q, ra1_q, ra2_q;
    logic [IW-1:0] imm_q;
    logic [DW-1:0] a_q, b_q, y_q, result_q;
    logic          c_q, z_q, flag_z_q, flag_c_q;
    logic [DW-1:0] imm_sext, alu_y;
    logic          alu_c, alu_z, accept;

    assign accept   = cmd_valid && cmd_ready;
    assign imm_sext = {{(DW-IW){imm_q[IW-1]}}, imm_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The read addresses are the latched rs1/rs2 themselves, so they are
    // already stable on the bank ports for the whole READ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            rd_q     <= '0;
            ra1_q    <= '0;
            ra2_q    <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= op_e'(cmd_op);
                rd_q  <= cmd_rd;
                ra1_q <= cmd_rs1;
                ra2_q <= cmd_rs2;
                imm_q <= cmd_imm;
            end
            if (state_q == S_READ) begin
                a_q <= rd1;
                b_q <= rd2;
            end
            if (state_q == S_EXEC) begin
                y_q <= alu_y;
                c_q <= alu_c;
                z_q <= alu_z;
            end
            if (state_q == S_WRITE) begin
                result_q <= y_q;
                flag_z_q <= z_q;
                flag_c_q <= c_q;
            end
        end
    end

    reg_seq_alu #(.DW(DW)) u_alu (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .imm_i (imm_sext),
        .y_o   (alu_y),
        .c_o   (alu_c),
        .z_o   (alu_z)
    );

    // Strobes decode straight from state so an async reset kills them at once.
    assign cmd_ready = (state_q == S_IDLE);
    assign w_en      = (state_q == S_WRITE);
    assign done      = w_en;
    assign ra1       = ra1_q;
    assign ra2       = ra2_q;
    assign wa        = rd_q;
    assign wd        = y_q;
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench: sequencer plus a behavioural 16x32 register bank.
module tb_reg_op_sequencer;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int IW = 16;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, MOV = 3'd5, LDI = 3'd6, ADDI = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [AW-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [IW-1:0] cmd_imm = '0;
    logic [AW-1:0] ra1, ra2, wa;
    logic [DW-1:0] rd1, rd2, wd, result;
    logic          w_en, done, flag_z, flag_c;

    logic [DW-1:0] bank [16];
    int            checks = 0;
    int            errors = 0;
    int            wcnt = 0;

    always #5 clk = ~clk;

    assign rd1 = bank[ra1];
    assign rd2 = bank[ra2];
    always @(posedge clk) begin
        if (w_en) begin
            bank[wa] <= wd;
            wcnt     <= wcnt + 1;
        end
    end

    reg_op_sequencer #(.DW(DW), .AW(AW), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .ra1       (ra1),
        .rd1       (rd1),
        .ra2       (ra2),
        .rd2       (rd2),
        .w_en      (w_en),
        .wa        (wa),
        .wd        (wd),
        .done      (done),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"},  cmd_ready, 1);
        chk({tag, "_wen"},    w_en,      0);
        chk({tag, "_done"},   done,      0);
        chk({tag, "_ra1"},    ra1,       0);
        chk({tag, "_ra2"},    ra2,       0);
        chk({tag, "_wa"},     wa,        0);
        chk({tag, "_wd"},     wd,        0);
        chk({tag, "_result"}, result,    0);
        chk({tag, "_fz"},     flag_z,    0);
        chk({tag, "_fc"},     flag_c,    0);
    endtask

    // One full command: checks READ/EXEC/WRITE cycles and the flags after.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [3:0] rd,
                          input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [15:0] imm, input logic [31:0] ewd, input logic ec);
        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_rd_ready"}, cmd_ready, 0);
        chk({tag, "_rd_ra1"},   ra1, rs1);
        chk({tag, "_rd_ra2"},   ra2, rs2);
        chk({tag, "_rd_wen"},   w_en, 0);
        @(negedge clk);
        chk({tag, "_ex_wen"},   w_en, 0);
        @(negedge clk);
        chk({tag, "_wr_wen"},   w_en, 1);
        chk({tag, "_wr_done"},  done, 1);
        chk({tag, "_wr_wa"},    wa, rd);
        chk({tag, "_wr_wd"},    wd, ewd);
        @(negedge clk);
        chk({tag, "_result"},   result, ewd);
        chk({tag, "_fz"},       flag_z, (ewd == 32'h0));
        chk({tag, "_fc"},       flag_c, ec);
        chk({tag, "_ready"},    cmd_ready, 1);
        chk({tag, "_wen_off"},  w_en, 0);
    endtask

    initial begin
        int acc;
        int acc_cyc [3];
        int w0;
        for (int i = 0; i < 16; i++) bank[i] = '0;

        repeat (2) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;

        do_cmd("ldi_r3",  LDI,  4'd3, 4'd0, 4'd0, 16'h8001, 32'hFFFF8001, 1'b0);
        do_cmd("ldi_r1",  LDI,  4'd1, 4'd0, 4'd0, 16'h0005, 32'h00000005, 1'b0);
        do_cmd("ldi_r2",  LDI,  4'd2, 4'd0, 4'd0, 16'h0007, 32'h00000007, 1'b0);
        do_cmd("add_r4",  ADD,  4'd4, 4'd1, 4'd2, 16'h0000, 32'h0000000C, 1'b0);
        do_cmd("sub_r5",  SUB,  4'd5, 4'd1, 4'd2, 16'h0000, 32'hFFFFFFFE, 1'b1);
        do_cmd("ldi_m1",  LDI,  4'd1, 4'd0, 4'd0, 16'hFFFF, 32'hFFFFFFFF, 1'b0);
        do_cmd("addi_r1", ADDI, 4'd1, 4'd1, 4'd0, 16'h0001, 32'h00000000, 1'b1);
        do_cmd("mov_r6",  MOV,  4'd6, 4'd1, 4'd0, 16'h0000, 32'h00000000, 1'b0);
        do_cmd("xor_r7",  XOR_, 4'd7, 4'd2, 4'd2, 16'h0000, 32'h00000000, 1'b0);
        do_cmd("and_r2",  AND_, 4'd2, 4'd2, 4'd2, 16'h0000, 32'h00000007, 1'b0);
        do_cmd("or_r9",   OR_,  4'd9, 4'd3, 4'd2, 16'h0000, 32'hFFFF8007, 1'b0);
        chk("bank_r4", bank[4], 32'h0000000C);

        // Valid held high across three back-to-back commands.
        @(negedge clk);
        cmd_op = LDI; cmd_rd = 4'd8; cmd_imm = 16'd1; cmd_valid = 1'b1;
        acc = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            logic took;
            took = 1'b0;
            chk("hold_ready", cmd_ready, ((cyc % 4 == 0) || cyc > 12));
            if (cmd_valid && cmd_ready) begin
                if (acc < 3) acc_cyc[acc] = cyc;
                acc++;
                took = 1'b1;
            end
            @(posedge clk);
            #1;
            if (took) begin
                cmd_rd  = cmd_rd + 4'd1;
                cmd_imm = cmd_imm + 16'd1;
                if (acc >= 3) cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("hold_accepts", acc, 3);
        chk("hold_gap01", acc_cyc[1] - acc_cyc[0], 4);
        chk("hold_gap12", acc_cyc[2] - acc_cyc[1], 4);
        chk("hold_r8",  bank[8],  32'd1);
        chk("hold_r9",  bank[9],  32'd2);
        chk("hold_r10", bank[10], 32'd3);

        // Reset during EXEC of ADD r4=r3+r2 must leave r4 untouched.
        cmd_op = ADD; cmd_rd = 4'd4; cmd_rs1 = 4'd3; cmd_rs2 = 4'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        w0 = wcnt;
        #1 rst_n = 1'b0;
        #1 chk_reset_outs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_nowrite", wcnt, w0);
        chk("midrst_r4", bank[4], 32'h0000000C);

        do_cmd("add_r11", ADD, 4'd11, 4'd1, 4'd2, 16'h0000, 32'h00000007, 1'b0);
        chk("bank_r11", bank[11], 32'h00000007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
